// File: rtl/iob_sched.sv
// IO bus scheduler: queues posted writes and serves reads, with writes given priority, plus a REQ watchdog.
// Define IOB_POSTED_WRITE_EN for a 2-entry write queue; otherwise the queue holds a single write.
module iob_sched #(
    parameter int WDT = 200
) (
    input  logic C16M,
    input  logic nRES,
    input  logic WRREQ,
    input  logic WRLDS,
    input  logic WRUDS,
    output logic WRFULL,
    output logic PUSHSLOT,
    input  logic RDREQ,
    input  logic RDLDS,
    input  logic RDUDS,
    output logic RDACK,
    output logic IOREQ,
    output logic IOLDS,
    output logic IOUDS,
    output logic IOWE,
    input  logic IOACT,
    output logic WSLOT,
    output logic BUSY,
    output logic TOERR
);

`ifdef IOB_POSTED_WRITE_EN
    localparam logic [1:0] DEPTH    = 2'd2;
    localparam logic       PTR_STEP = 1'b1;
`else
    // Single entry: pointers never move, so both slot outputs stay 0.
    localparam logic [1:0] DEPTH    = 2'd1;
    localparam logic       PTR_STEP = 1'b0;
`endif
    localparam int WW = (WDT > 1) ? $clog2(WDT) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_ACT, ST_DONE} state_t;

    state_t            state_q, state_d;
    logic              head_q, head_d;
    logic              tail_q, tail_d;
    logic [1:0]        count_q, count_d;
    logic [1:0][1:0]   ent_q, ent_d;
    logic              io_we_q, io_we_d;
    logic              io_lds_q, io_lds_d;
    logic              io_uds_q, io_uds_d;
    logic              wslot_q, wslot_d;
    logic [WW-1:0]     wdt_q, wdt_d;
    logic              rdack_q, rdack_d;
    logic              toerr_q, toerr_d;
    logic              rd_block_q, rd_block_d;
    logic              push, pop;

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        ent_d      = ent_q;
        io_we_d    = io_we_q;
        io_lds_d   = io_lds_q;
        io_uds_d   = io_uds_q;
        wslot_d    = wslot_q;
        wdt_d      = wdt_q;
        rdack_d    = 1'b0;
        toerr_d    = 1'b0;
        rd_block_d = 1'b0;
        pop        = 1'b0;
        push       = WRREQ && (count_q < DEPTH);

        case (state_q)
            ST_IDLE: begin
                // Queued writes go first so a read always observes every posted write.
                if (count_q != 2'd0) begin
                    io_we_d  = 1'b1;
                    io_lds_d = ent_q[head_q][1];
                    io_uds_d = ent_q[head_q][0];
                    wslot_d  = head_q;
                    wdt_d    = '0;
                    state_d  = ST_REQ;
                end else if (RDREQ && !rd_block_q) begin
                    io_we_d  = 1'b0;
                    io_lds_d = RDLDS;
                    io_uds_d = RDUDS;
                    wslot_d  = 1'b0;
                    wdt_d    = '0;
                    state_d  = ST_REQ;
                end
            end
            ST_REQ: begin
                if (IOACT) begin
                    state_d = ST_ACT;
                end else if (wdt_q == WW'(WDT - 1)) begin
                    state_d    = ST_IDLE;
                    toerr_d    = 1'b1;
                    pop        = io_we_q;
                    rdack_d    = !io_we_q;
                    rd_block_d = !io_we_q;
                end else begin
                    wdt_d = wdt_q + WW'(1);
                end
            end
            ST_ACT: begin
                if (!IOACT) begin
                    state_d = ST_DONE;
                    rdack_d = !io_we_q;
                end
            end
            ST_DONE: begin
                // The requester may still hold RDREQ for one cycle after seeing RDACK.
                state_d    = ST_IDLE;
                pop        = io_we_q;
                rd_block_d = !io_we_q;
            end
            default: state_d = ST_IDLE;
        endcase

        if (push) begin
            ent_d[tail_q] = {WRLDS, WRUDS};
            tail_d        = tail_q ^ PTR_STEP;
        end
        if (pop) begin
            head_d = head_q ^ PTR_STEP;
        end
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge C16M or negedge nRES) begin
        if (!nRES) begin
            state_q    <= ST_IDLE;
            head_q     <= 1'b0;
            tail_q     <= 1'b0;
            count_q    <= 2'd0;
            // NOTE: the queue storage is only two flop pairs, so it shares the async reset with the rest.
            ent_q      <= '0;
            io_we_q    <= 1'b0;
            io_lds_q   <= 1'b0;
            io_uds_q   <= 1'b0;
            wslot_q    <= 1'b0;
            wdt_q      <= '0;
            rdack_q    <= 1'b0;
            toerr_q    <= 1'b0;
            rd_block_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values.
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ent_q      <= ent_d;
            io_we_q    <= io_we_d;
            io_lds_q   <= io_lds_d;
            io_uds_q   <= io_uds_d;
            wslot_q    <= wslot_d;
            wdt_q      <= wdt_d;
            rdack_q    <= rdack_d;
            toerr_q    <= toerr_d;
            rd_block_q <= rd_block_d;
        end
    end

    assign IOREQ    = (state_q == ST_REQ);
    assign BUSY     = (state_q != ST_IDLE);
    assign WRFULL   = (count_q == DEPTH);
    assign PUSHSLOT = tail_q;
    assign WSLOT    = wslot_q;
    assign IOWE     = io_we_q;
    assign IOLDS    = io_lds_q;
    assign IOUDS    = io_uds_q;
    assign RDACK    = rdack_q;
    assign TOERR    = toerr_q;

endmodule

// File: tb/tb_iob_sched.sv
// Self-checking bench for iob_sched: directed scenarios plus randomized write/read groups
// checked against a queue-based model of the write FIFO and the request order.
module tb_iob_sched;

`ifdef IOB_POSTED_WRITE_EN
    localparam int DEPTH  = 2;
    localparam bit POSTED = 1'b1;
`else
    localparam int DEPTH  = 1;
    localparam bit POSTED = 1'b0;
`endif
    localparam int WDT = 200;

    logic C16M = 1'b0;
    logic nRES = 1'b0;
    logic WRREQ = 1'b0, WRLDS = 1'b0, WRUDS = 1'b0;
    logic RDREQ = 1'b0, RDLDS = 1'b0, RDUDS = 1'b0;
    logic IOACT = 1'b0;
    logic WRFULL, PUSHSLOT, RDACK, IOREQ, IOLDS, IOUDS, IOWE, WSLOT, BUSY, TOERR;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: expected bus transactions {we, slot, lds, uds} in issue order.
    logic [3:0] mq[$];
    int         mcount;
    logic       mtail;
    bit         rd_pending;
    logic [1:0] rd_strb;

    iob_sched #(.WDT(WDT)) dut (
        .C16M(C16M), .nRES(nRES),
        .WRREQ(WRREQ), .WRLDS(WRLDS), .WRUDS(WRUDS), .WRFULL(WRFULL), .PUSHSLOT(PUSHSLOT),
        .RDREQ(RDREQ), .RDLDS(RDLDS), .RDUDS(RDUDS), .RDACK(RDACK),
        .IOREQ(IOREQ), .IOLDS(IOLDS), .IOUDS(IOUDS), .IOWE(IOWE),
        .IOACT(IOACT), .WSLOT(WSLOT), .BUSY(BUSY), .TOERR(TOERR)
    );

    always #5 C16M = ~C16M;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    function automatic logic exp_full();
        return (mcount == DEPTH);
    endfunction

    function automatic void model_clear();
        mq.delete();
        mcount     = 0;
        mtail      = 1'b0;
        rd_pending = 1'b0;
    endfunction

    function automatic void model_push(input logic lds, input logic uds);
        if (mcount < DEPTH) begin
            mq.push_back({1'b1, mtail, lds, uds});
            mcount++;
            if (POSTED) mtail = ~mtail;
        end
    endfunction

    function automatic void model_pop();
        void'(mq.pop_front());
        mcount--;
    endfunction

    task automatic do_reset();
        nRES = 1'b0;
        WRREQ = 1'b0; RDREQ = 1'b0; IOACT = 1'b0;
        model_clear();
        repeat (2) @(negedge C16M);
        nRES = 1'b1;
        @(negedge C16M);
    endtask

    task automatic push(input logic lds, input logic uds);
        n_tests++; if (WRFULL !== exp_full()) begin n_fail++; $display("FAIL push_wrfull: got %b want %b", WRFULL, exp_full()); end
        n_tests++; if (PUSHSLOT !== mtail) begin n_fail++; $display("FAIL push_slot: got %b want %b", PUSHSLOT, mtail); end
        WRREQ = 1'b1; WRLDS = lds; WRUDS = uds;
        model_push(lds, uds);
        @(negedge C16M);
        WRREQ = 1'b0;
    endtask

    // Acts as the bus master for one transaction and checks it against the head of the model.
    task automatic serve(input int lat, input int hold, output int rdacks);
        logic [3:0] exp;
        logic [3:0] got;
        bit         is_wr;
        int         n;
        int         hi;
        rdacks = 0;
        is_wr  = (mq.size() > 0);
        exp    = is_wr ? mq[0] : {2'b00, rd_strb};
        n = 0;
        while (IOREQ !== 1'b1 && n < 400) begin @(negedge C16M); n++; end
        n_tests++;
        if (IOREQ !== 1'b1) begin n_fail++; $display("FAIL serve_ioreq_timeout: IOREQ=%b after %0d cycles", IOREQ, n); return; end
        got = {IOWE, WSLOT, IOLDS, IOUDS};
        n_tests++;
        if ({got[3], got[1:0]} !== {exp[3], exp[1:0]} || (is_wr && got[2] !== exp[2])) begin
            n_fail++; $display("FAIL serve_txn: got we/slot/lds/uds=%b want %b (write=%0b)", got, exp, is_wr);
        end
        hi = 1;
        for (int i = 1; i < lat; i++) begin @(negedge C16M); if (IOREQ === 1'b1) hi++; end
        n_tests++; if (hi != lat) begin n_fail++; $display("FAIL serve_req_len: IOREQ high %0d cycles, want %0d", hi, lat); end
        IOACT = 1'b1;
        @(negedge C16M);
        n_tests++; if ({IOREQ, BUSY} !== 2'b01) begin n_fail++; $display("FAIL serve_act: IOREQ/BUSY=%b%b want 01", IOREQ, BUSY); end
        repeat (hold - 1) @(negedge C16M);
        IOACT = 1'b0;
        @(negedge C16M);
        rdacks += int'(RDACK);
        n_tests++; if ({BUSY, RDACK, TOERR} !== {1'b1, !is_wr, 1'b0}) begin n_fail++; $display("FAIL serve_done: BUSY/RDACK/TOERR=%b%b%b want 1%b0", BUSY, RDACK, TOERR, !is_wr); end
        n_tests++; if ({IOWE, WSLOT, IOLDS, IOUDS} !== got) begin n_fail++; $display("FAIL serve_hold: strobes=%b want %b", {IOWE, WSLOT, IOLDS, IOUDS}, got); end
        n_tests++; if (WRFULL !== exp_full()) begin n_fail++; $display("FAIL serve_done_full: got %b want %b", WRFULL, exp_full()); end
        @(negedge C16M);
        rdacks += int'(RDACK);
        if (is_wr) model_pop();
        else begin RDREQ = 1'b0; rd_pending = 1'b0; end
        n_tests++; if ({BUSY, RDACK} !== 2'b00) begin n_fail++; $display("FAIL serve_idle: BUSY/RDACK=%b%b want 00", BUSY, RDACK); end
        n_tests++; if ({WRFULL, PUSHSLOT} !== {exp_full(), mtail}) begin n_fail++; $display("FAIL serve_pop: WRFULL/PUSHSLOT=%b%b want %b%b", WRFULL, PUSHSLOT, exp_full(), mtail); end
    endtask

    task automatic test_reset();
        nRES = 1'b0;
        #3;
        n_tests++;
        if ({IOREQ, IOLDS, IOUDS, IOWE, WSLOT, RDACK, TOERR, BUSY, WRFULL, PUSHSLOT} !== 10'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b want 0000000000", {IOREQ, IOLDS, IOUDS, IOWE, WSLOT, RDACK, TOERR, BUSY, WRFULL, PUSHSLOT});
        end
        do_reset();
        n_tests++; if ({BUSY, WRFULL, IOREQ} !== 3'b000) begin n_fail++; $display("FAIL reset_release: BUSY/WRFULL/IOREQ=%b want 000", {BUSY, WRFULL, IOREQ}); end
    endtask

    task automatic test_single_write();
        int r;
        push(1'b1, 1'b1);
        serve(3, 6, r);
        n_tests++; if (r != 0) begin n_fail++; $display("FAIL single_rdack: got %0d pulses want 0", r); end
    endtask

    task automatic test_back_to_back();
        int r, total, n;
        push(1'b0, 1'b1);
        push(1'b1, 1'b0);
        n_tests++; if (WRFULL !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b want 1", WRFULL); end
        RDREQ = 1'b1; RDLDS = 1'b1; RDUDS = 1'b1; rd_strb = 2'b11; rd_pending = 1'b1;
        n = mq.size() + 1;
        total = 0;
        for (int i = 0; i < n; i++) begin serve(2, 3, r); total += r; end
        n_tests++; if (total != 1) begin n_fail++; $display("FAIL b2b_rdack: got %0d pulses want 1", total); end
    endtask

    task automatic test_push_pop();
        int n, r;
        push(1'b0, 1'b1);
        n = 0;
        while (IOREQ !== 1'b1 && n < 50) begin @(negedge C16M); n++; end
        n_tests++; if (IOREQ !== 1'b1) begin n_fail++; $display("FAIL pp_ioreq: got %b want 1", IOREQ); end
        IOACT = 1'b1;
        repeat (2) @(negedge C16M);
        IOACT = 1'b0;
        @(negedge C16M);
        // Push lands in the DONE cycle, on the same edge as the pop.
        WRREQ = 1'b1; WRLDS = 1'b1; WRUDS = 1'b0;
        model_push(1'b1, 1'b0);
        model_pop();
        @(negedge C16M);
        WRREQ = 1'b0;
        n_tests++; if ({WRFULL, PUSHSLOT, BUSY} !== {exp_full(), mtail, 1'b0}) begin
            n_fail++; $display("FAIL pp_state: WRFULL/PUSHSLOT/BUSY=%b%b%b want %b%b0", WRFULL, PUSHSLOT, BUSY, exp_full(), mtail);
        end
        if (POSTED) serve(2, 2, r);
        repeat (2) @(negedge C16M);
        n_tests++; if ({BUSY, WRFULL} !== 2'b00) begin n_fail++; $display("FAIL pp_drain: BUSY/WRFULL=%b%b want 00", BUSY, WRFULL); end
    endtask

    task automatic test_watchdog(input bit is_write);
        int n, hi;
        if (is_write) push(1'b1, 1'b0);
        else begin RDREQ = 1'b1; RDLDS = 1'b0; RDUDS = 1'b1; rd_strb = 2'b01; rd_pending = 1'b1; end
        n = 0;
        while (IOREQ !== 1'b1 && n < 50) begin @(negedge C16M); n++; end
        hi = 0;
        n = 0;
        while (IOREQ === 1'b1 && n < 1000) begin hi++; @(negedge C16M); n++; end
        n_tests++; if (hi != WDT) begin n_fail++; $display("FAIL wdt_len: IOREQ high %0d cycles want %0d (write=%0b)", hi, WDT, is_write); end
        n_tests++; if ({TOERR, RDACK, BUSY, IOREQ} !== {1'b1, !is_write, 2'b00}) begin
            n_fail++; $display("FAIL wdt_abort: TOERR/RDACK/BUSY/IOREQ=%b want 1%b00", {TOERR, RDACK, BUSY, IOREQ}, !is_write);
        end
        if (is_write) model_pop();
        @(negedge C16M);
        n_tests++; if ({TOERR, RDACK, WRFULL, BUSY} !== {3'b000, 1'b0}) begin
            n_fail++; $display("FAIL wdt_after: TOERR/RDACK/WRFULL/BUSY=%b want 0000", {TOERR, RDACK, WRFULL, BUSY});
        end
        RDREQ = 1'b0; rd_pending = 1'b0;
        @(negedge C16M);
        n_tests++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL wdt_no_reaccept: BUSY=%b want 0", BUSY); end
    endtask

    task automatic test_reset_mid();
        int n, rdacks;
        bit busy_seen;
        for (int v = 0; v < 2; v++) begin
            push(1'b1, 1'b1);
            push(1'b0, 1'b1);
            RDREQ = 1'b1; RDLDS = 1'b1; RDUDS = 1'b0;
            n = 0;
            while (IOREQ !== 1'b1 && n < 50) begin @(negedge C16M); n++; end
            if (v == 1) begin IOACT = 1'b1; repeat (2) @(negedge C16M); end
            n_tests++; if (WRFULL !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_full: v=%0d got %b want 1", v, WRFULL); end
            #2 nRES = 1'b0;
            #1;
            n_tests++; if ({IOREQ, BUSY, WRFULL, RDACK, PUSHSLOT, IOWE} !== 6'b0) begin
                n_fail++; $display("FAIL rstmid_async: v=%0d IOREQ/BUSY/WRFULL/RDACK/PUSHSLOT/IOWE=%b want 000000", v, {IOREQ, BUSY, WRFULL, RDACK, PUSHSLOT, IOWE});
            end
            RDREQ = 1'b0; IOACT = 1'b0;
            model_clear();
            @(negedge C16M);
            nRES = 1'b1;
            rdacks = 0; busy_seen = 1'b0;
            repeat (10) begin @(negedge C16M); rdacks += int'(RDACK); busy_seen |= BUSY; end
            n_tests++; if (rdacks != 0 || busy_seen) begin n_fail++; $display("FAIL rstmid_discard: v=%0d rdacks=%0d busy_seen=%0b want 0/0", v, rdacks, busy_seen); end
        end
    endtask

    task automatic test_random();
        int np, ntx, r, total;
        bit rd;
        for (int g = 0; g < 30; g++) begin
            np = int'($urandom_range(0, DEPTH + 1));
            rd = bit'($urandom_range(0, 1));
            if (np == 0) rd = 1'b1;
            for (int i = 0; i < np; i++) push(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
            if (rd) begin
                rd_strb = 2'($urandom_range(0, 3));
                RDREQ = 1'b1; RDLDS = rd_strb[1]; RDUDS = rd_strb[0]; rd_pending = 1'b1;
            end
            ntx = mq.size() + int'(rd);
            total = 0;
            for (int t = 0; t < ntx; t++) begin
                serve(int'($urandom_range(1, 6)), int'($urandom_range(1, 6)), r);
                total += r;
            end
            n_tests++; if (total != int'(rd)) begin n_fail++; $display("FAIL rand_rdack: group %0d got %0d pulses want %0d", g, total, int'(rd)); end
            @(negedge C16M);
            n_tests++; if ({BUSY, WRFULL} !== 2'b00) begin n_fail++; $display("FAIL rand_idle: group %0d BUSY/WRFULL=%b%b want 00", g, BUSY, WRFULL); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_write();
        test_back_to_back();
        test_push_pop();
        test_watchdog(1'b0);
        test_watchdog(1'b1);
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
